// File: rtl/mvm_proposed_core.sv
// ---------------------------------------------------------------------------
// mvm_proposed_core
//   One MVM row engine for the LSTM accelerator datapath. Computes a single
//   saturated output element v = sat(sum_i w[i]*u[i]) over S unsigned N-bit
//   operand pairs. The weights are consumed one bit at a time. For every
//   weight bit, each operand pair goes through a 4-way select
//   (0 / a / c / sat(a+c)), and the pair results are accumulated with
//   saturation. The per-bit sums are then shifted by their bit weight,
//   truncated to N bits, and added into the final result with saturation.
//   No add anywhere in the block wraps around.
//
//   w and u are registered once. v is combinational from those registers, so
//   the latency is 1 cycle.
//
// Parameters
//   N  element width (bits); all elements are unsigned
//   S  elements per vector; must be even and >= 2
//
// Ports
//   CLOCK_50  in   1     rising-edge clock
//   reset_n   in   1     asynchronous active-low reset; clears the input registers
//   w         in   S*N   weight vector, element i = w[(i+1)*N-1 -: N]
//   u         in   S*N   input vector,  element i = u[(i+1)*N-1 -: N]
//   v         out  N     saturated result element
//
// Configuration
//   MVM_OUT_REG_EN  when defined, v comes from an output register that loads
//                   the final sum on every posedge and resets asynchronously
//                   to 0. This makes the latency 2 cycles. When undefined
//                   (the default), v is combinational.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mvm_proposed_core #(
    parameter int N = 8,
    parameter int S = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [S*N-1:0]   w,
    input  logic [S*N-1:0]   u,
    output logic [N-1:0]     v
);

    localparam int P = S / 2;

    // Unsigned N-bit add that clamps to all-ones when it carries out.
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] x,
                                             input logic [N-1:0] y);
        logic [N:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[N] ? {N{1'b1}} : sum[N-1:0];
    endfunction

    logic [S*N-1:0] w_r;
    logic [S*N-1:0] u_r;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its input from before the clock edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            w_r <= '0;
            u_r <= '0;
        end else begin
            w_r <= w;
            u_r <= u;
        end
    end

    // Unpack the registered vectors into element arrays, using constant indices.
    logic [N-1:0] w_e [S];
    logic [N-1:0] u_e [S];

    for (genvar i = 0; i < S; i++) begin : g_unpack
        assign w_e[i] = w_r[(i+1)*N-1 -: N];
        assign u_e[i] = u_r[(i+1)*N-1 -: N];
    end

    // part[b][p]  running saturated sum of the pair selects 0..p for weight bit b
    // acc[b]      running saturated final sum over weight bits 0..b-1
    logic [N-1:0] part [N][P];
    logic [N-1:0] acc  [N+1];

    assign acc[0] = '0;

    for (genvar b = 0; b < N; b++) begin : g_bit
        for (genvar p = 0; p < P; p++) begin : g_pair
            logic [N-1:0] sel;

            // NOTE: sel gets a default before the case, so no path through
            // the block can leave it unassigned and infer a latch.
            always_comb begin
                sel = '0;
                case ({w_e[2*p+1][b], w_e[2*p][b]})
                    2'b01:   sel = u_e[2*p];
                    2'b10:   sel = u_e[2*p+1];
                    2'b11:   sel = sat_add(u_e[2*p], u_e[2*p+1]);
                    default: sel = '0;
                endcase
            end

            if (p == 0) begin : g_first
                assign part[b][p] = sel;
            end else begin : g_accum
                assign part[b][p] = sat_add(part[b][p-1], sel);
            end
        end

        // The bits shifted past N-1 are dropped on purpose, not saturated.
        // Only the add below saturates.
        logic [N-1:0] shifted;
        assign shifted  = part[b][P-1] << b;
        assign acc[b+1] = sat_add(acc[b], shifted);
    end

`ifdef MVM_OUT_REG_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
        end else begin
            v <= acc[N];
        end
    end
`else
    assign v = acc[N];
`endif

endmodule

// File: tb/tb_mvm_proposed_core.sv
// ---------------------------------------------------------------------------
// tb_mvm_proposed_core
//   Directed and random checks of mvm_proposed_core in its default build
//   (N=8, S=8, combinational output). Vectors are driven at negedge.
//   v is checked 1ps after the following posedge. It is also checked 1ps
//   after each drive, to confirm that v still holds the previous result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mvm_proposed_core;

    localparam int N = 8;
    localparam int S = 8;

    typedef logic [N-1:0] vec_t [S];

    logic             CLOCK_50;
    logic             reset_n;
    logic [S*N-1:0]   w;
    logic [S*N-1:0]   u;
    logic [N-1:0]     v;

    int checks;
    int errors;
    logic [N-1:0] last_exp;

    mvm_proposed_core #(.N(N), .S(S)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .w        (w),
        .u        (u),
        .v        (v)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: v=%0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [S*N-1:0] pack(input vec_t e);
        logic [S*N-1:0] r;
        for (int i = 0; i < S; i++) r[(i+1)*N-1 -: N] = e[i];
        return r;
    endfunction

    function automatic int clamp(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Reference model written in plain integer arithmetic.
    function automatic logic [N-1:0] model(input vec_t we, input vec_t ue);
        int acc, bs, sel, a, c;
        logic [N-1:0] r;
        acc = 0;
        for (int b = 0; b < N; b++) begin
            bs = 0;
            for (int p = 0; p < S/2; p++) begin
                a = int'(ue[2*p]);
                c = int'(ue[2*p+1]);
                case ({we[2*p+1][b], we[2*p][b]})
                    2'b01:   sel = a;
                    2'b10:   sel = c;
                    2'b11:   sel = clamp(a + c);
                    default: sel = 0;
                endcase
                bs = (p == 0) ? sel : clamp(bs + sel);
            end
            acc = clamp(acc + ((bs << b) & 255));
        end
        r = acc[N-1:0];
        return r;
    endfunction

    // Drive at negedge, confirm v holds, then check 1ps after the posedge.
    task automatic apply(input string tag, input vec_t we, input vec_t ue,
                         input logic [N-1:0] exp);
        @(negedge CLOCK_50);
        w = pack(we);
        u = pack(ue);
        #1ps;
        check({tag, "_hold"}, v, last_exp);
        @(posedge CLOCK_50);
        #1ps;
        check(tag, v, exp);
        last_exp = exp;
    endtask

    vec_t we, ue;

    initial begin
        checks   = 0;
        errors   = 0;
        last_exp = '0;

        // v stays 0 while reset is held, even with all-ones inputs.
        reset_n = 1'b0;
        w = '1;
        u = '1;
        repeat (3) @(posedge CLOCK_50);
        #1ps;
        check("reset_ones", v, 8'd0);

        // Release with the inputs still all-ones. The first posedge captures them.
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        #1ps;
        check("release_hold", v, 8'd0);
        @(posedge CLOCK_50);
        #1ps;
        check("release_capture", v, 8'd255);
        last_exp = 8'd255;

        // All weights are zero.
        we = '{default: 8'd0};
        ue = '{8'd17, 8'd200, 8'd3, 8'd99, 8'd255, 8'd1, 8'd64, 8'd8};
        apply("w_zero", we, ue, 8'd0);

        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd1; ue[0] = 8'd5;
        apply("sel01", we, ue, 8'd5);

        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd1; we[1] = 8'd1; ue[0] = 8'd3; ue[1] = 8'd4;
        apply("sel11", we, ue, 8'd7);

        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd2; ue[0] = 8'd5;
        apply("bit1_weight", we, ue, 8'd10);

        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd128; ue[0] = 8'd3;
        apply("shift_trunc", we, ue, 8'd128);

        // The c input of a pair, weighted by bit 2: 6<<2 = 24.
        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[1] = 8'd4; ue[1] = 8'd6;
        apply("sel10_bit2", we, ue, 8'd24);

        // Two different pairs accumulate: 7 + 9 = 16.
        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[2] = 8'd1; ue[2] = 8'd7; we[4] = 8'd1; ue[4] = 8'd9;
        apply("pair_accum", we, ue, 8'd16);

        // The pair add saturates: 200 + 100 -> 255.
        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd1; we[1] = 8'd1; ue[0] = 8'd200; ue[1] = 8'd100;
        apply("pair_sat", we, ue, 8'd255);

        // The final add saturates: 200 + (400 & 255 = 144) -> 255.
        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[0] = 8'd3; ue[0] = 8'd200;
        apply("final_sat", we, ue, 8'd255);

        we = '{default: 8'd255}; ue = '{default: 8'd255};
        apply("all_ones", we, ue, 8'd255);

        // A vector that gives a small result, so the mid-stream reset below is visible.
        we = '{default: 8'd0}; ue = '{default: 8'd0};
        we[6] = 8'd1; ue[6] = 8'd9;
        apply("pre_reset", we, ue, 8'd9);

        // Asynchronous reset asserted between edges clears v at once.
        @(negedge CLOCK_50);
        #2;
        reset_n = 1'b0;
        #1ps;
        check("async_reset", v, 8'd0);
        @(posedge CLOCK_50);
        #1ps;
        check("reset_held", v, 8'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1ps;
        check("reset_recapture", v, 8'd9);
        last_exp = 8'd9;

        // Random vectors with small elements, checked against the model.
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < S; i++) begin
                we[i] = 8'($urandom_range(10, 0));
                ue[i] = 8'($urandom_range(10, 0));
            end
            apply("random", we, ue, model(we, ue));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
